// File: rtl/frame_write_burst_ctrl.sv
// frame_write_burst_ctrl
// Accepts a per-frame write request, flushes the pixel FIFO and then drains
// one full frame into memory as a series of fixed-length burst writes.
// The frame base address rotates between four buffers selected by a 2-bit index.
// Optional feature: define FRAME_WRITE_OVERFLOW_CHK_EN to enable the sticky
// FIFO overflow flag (overflow_err); otherwise it is tied low.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no frame in progress, waiting for write_req
// ACK       | one cycle: acknowledge request, flush FIFO, load frame base
// WAIT_DATA | waiting until the FIFO holds enough words for the next burst
// BURST     | burst request outstanding, waiting for wr_burst_finish
// DONE      | one cycle: frame_done pulse after the last burst

module frame_write_burst_ctrl #(
    parameter int ADDR_BITS         = 25,
    parameter int BURST_LEN         = 64,
    parameter int FRAME_LEN         = 1024*768/4,
    parameter int FRAME_STRIDE_LOG2 = 21,
    parameter int CNT_BITS          = 10
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 write_req,
    input  logic [1:0]           write_addr_index,
    output logic                 write_req_ack,
    output logic                 fifo_flush,
    input  logic [CNT_BITS-1:0]  fifo_rd_count,
    input  logic                 fifo_full,
    output logic                 wr_burst_req,
    output logic [ADDR_BITS-1:0] wr_burst_addr,
    output logic [CNT_BITS-1:0]  wr_burst_len,
    input  logic                 wr_burst_finish,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overflow_err
);

    // Word-count width wide enough for the frame length, the burst length
    // and the FIFO count, so all length comparisons happen without truncation.
    localparam int REM_BITS = $clog2(FRAME_LEN + 1);
    localparam int BL_BITS  = $clog2(BURST_LEN + 1);
    localparam int W0       = (REM_BITS > BL_BITS) ? REM_BITS : BL_BITS;
    localparam int W        = (W0 > CNT_BITS) ? W0 : CNT_BITS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK       = 3'd1,
        WAIT_DATA = 3'd2,
        BURST     = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] base;
    logic [ADDR_BITS-1:0] offset;
    logic [W-1:0]         remaining;
    logic [W-1:0]         len_q;
    logic [ADDR_BITS-1:0] addr_q;

    logic [W-1:0]         cur_len;
    logic                 launch;
    logic                 finish;
    logic                 last_burst;

    // Length of the next burst: a full burst, or whatever is left of the frame.
    always_comb begin
        cur_len = W'(BURST_LEN);
        if (remaining < W'(BURST_LEN)) begin
            cur_len = remaining;
        end
    end

    assign last_burst = (remaining == len_q);

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt     = state;
        write_req_ack = 1'b0;
        fifo_flush    = 1'b0;
        wr_burst_req  = 1'b0;
        frame_done    = 1'b0;
        busy          = 1'b1;
        launch        = 1'b0;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (write_req) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                write_req_ack = 1'b1;
                fifo_flush    = 1'b1;
                state_nxt     = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (write_req) begin
                    state_nxt = ACK;
                end else if (W'(fifo_rd_count) >= cur_len) begin
                    launch    = 1'b1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                wr_burst_req = 1'b1;
                if (wr_burst_finish) begin
                    finish = 1'b1;
                    // A pending new-frame request wins over finishing this frame.
                    if (write_req) begin
                        state_nxt = ACK;
                    end else if (last_burst) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = write_req ? ACK : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame progress and burst descriptor registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            base      <= '0;
            offset    <= '0;
            remaining <= '0;
            len_q     <= '0;
            addr_q    <= '0;
        end else begin
            if (state == ACK) begin
                // Shifting after zero-extension is the same as truncating
                // {index, zeros} to ADDR_BITS.
                base      <= ADDR_BITS'(write_addr_index) << FRAME_STRIDE_LOG2;
                offset    <= '0;
                remaining <= W'(FRAME_LEN);
            end
            if (launch) begin
                addr_q <= base + offset;
                len_q  <= cur_len;
            end
            if (finish) begin
                offset    <= offset + ADDR_BITS'(len_q);
                remaining <= remaining - len_q;
            end
        end
    end

    assign wr_burst_addr = addr_q;
    assign wr_burst_len  = len_q[CNT_BITS-1:0];

`ifdef FRAME_WRITE_OVERFLOW_CHK_EN
    logic overflow_q;

    // Sticky overflow flag while the frame is being drained; cleared at frame start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (state == ACK) begin
            overflow_q <= 1'b0;
        end else if (fifo_full && (state == WAIT_DATA || state == BURST)) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_err = overflow_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
    assign overflow_err     = 1'b0;
`endif

endmodule
